// File: rtl/counter32_pkg.sv
// Shared types and widths for the counter32 checker slice.
// Holds the checker FSM encoding plus the count and error-count widths.
package counter32_pkg;

    localparam int Q_W       = 32;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one edge after inc.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter32_checker.sv
// Compares a 32-bit counter against its scoreboard after a warm-up; optional rco check under COUNTER32_CHECKER_RCO_CHECK_EN.
// Latency: err pulses 2 edges after the sample is presented (sample register, then compare register).
// Backpressure: none; enable low simply pauses sampling, STOP_ON_ERR freezes in HALT until clear/reset.
module counter32_checker
    import counter32_pkg::*;
#(
    parameter int unsigned WARMUP      = 2,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [Q_W-1:0]       sb_Q,
    input  logic                 sb_rco,
    input  logic [Q_W-1:0]       dut_Q,
    input  logic                 dut_rco,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [Q_W-1:0]       cmp_cnt,
    output logic [Q_W-1:0]       first_sb_Q,
    output logic [Q_W-1:0]       first_dut_Q,
    output logic [Q_W-1:0]       first_idx,
    output logic [1:0]           state,
    output logic                 pass
);

    localparam logic [3:0] WARMUP_N = 4'(WARMUP);

    state_t         state_q, state_d;
    logic           valid_s;
    logic [Q_W-1:0] sb_q_s, dut_q_s;
    logic [3:0]     warm_cnt;
    logic           cmp_fire;
    logic           mismatch;
    logic           rco_diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_s <= 1'b0;
            sb_q_s  <= '0;
            dut_q_s <= '0;
        end else if (clear) begin
            valid_s <= 1'b0;
        end else if (enable) begin
            valid_s <= 1'b1;
            sb_q_s  <= sb_Q;
            dut_q_s <= dut_Q;
        end else begin
            valid_s <= 1'b0;
        end
    end

`ifdef COUNTER32_CHECKER_RCO_CHECK_EN
    logic sb_rco_s, dut_rco_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_rco_s  <= 1'b0;
            dut_rco_s <= 1'b0;
        end else if (enable && !clear) begin
            sb_rco_s  <= sb_rco;
            dut_rco_s <= dut_rco;
        end
    end

    assign rco_diff = (sb_rco_s != dut_rco_s);
`else
    logic unused_rco;

    assign unused_rco = sb_rco ^ dut_rco;
    assign rco_diff   = 1'b0;
`endif

    // The sample that leaves IDLE is the first warm-up sample; with WARMUP==0 it is compared instead.
    always_comb begin
        state_d  = state_q;
        cmp_fire = 1'b0;
        mismatch = 1'b0;
        if (valid_s) begin
            case (state_q)
                IDLE: begin
                    if (WARMUP == 0) begin
                        cmp_fire = 1'b1;
                        state_d  = CHECK;
                    end else if (WARMUP == 1) begin
                        state_d = CHECK;
                    end else begin
                        state_d = WARM;
                    end
                end
                WARM: begin
                    if ((warm_cnt + 4'd1) == WARMUP_N) begin
                        state_d = CHECK;
                    end
                end
                CHECK:   cmp_fire = 1'b1;
                default: ;
            endcase
        end
        mismatch = cmp_fire && ((sb_q_s != dut_q_s) || rco_diff);
        if (mismatch && STOP_ON_ERR) begin
            state_d = HALT;
        end
        if (clear) begin
            state_d  = IDLE;
            cmp_fire = 1'b0;
            mismatch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            warm_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                warm_cnt <= '0;
            end else if (valid_s && (state_q == IDLE)) begin
                warm_cnt <= 4'd1;
            end else if (valid_s && (state_q == WARM)) begin
                warm_cnt <= warm_cnt + 4'd1;
            end
        end
    end

    // first_idx records the compared-sample count including the failing sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err         <= 1'b0;
            cmp_cnt     <= '0;
            first_sb_Q  <= '0;
            first_dut_Q <= '0;
            first_idx   <= '0;
        end else if (clear) begin
            err         <= 1'b0;
            cmp_cnt     <= '0;
            first_sb_Q  <= '0;
            first_dut_Q <= '0;
            first_idx   <= '0;
        end else begin
            err <= mismatch;
            if (cmp_fire) begin
                cmp_cnt <= cmp_cnt + 32'd1;
            end
            if (mismatch && (err_cnt == '0)) begin
                first_sb_Q  <= sb_q_s;
                first_dut_Q <= dut_q_s;
                first_idx   <= cmp_cnt + 32'd1;
            end
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (mismatch),
        .cnt   (err_cnt)
    );

    assign state = state_q;
    assign pass  = ((state_q == CHECK) || (state_q == HALT)) && (err_cnt == '0);

endmodule

// File: tb/tb_counter32_checker.sv
// Directed bench for counter32_checker: two instances (free-running and stop-on-error) share stimulus.
// Table rows cover the first-mismatch capture and clear; hand sequences cover the multi-cycle corners.
module tb_counter32_checker;

`ifdef COUNTER32_CHECKER_RCO_CHECK_EN
    localparam bit RCO_EN = 1'b1;
`else
    localparam bit RCO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [31:0] sb_Q, dut_Q;
    logic        sb_rco, dut_rco;

    logic        a_err, b_err;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic [31:0] a_cmp, b_cmp;
    logic [31:0] a_fsb, b_fsb, a_fdq, b_fdq, a_fidx, b_fidx;
    logic [1:0]  a_state, b_state;
    logic        a_pass, b_pass;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    counter32_checker #(.WARMUP(2), .STOP_ON_ERR(1'b0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .sb_Q(sb_Q), .sb_rco(sb_rco), .dut_Q(dut_Q), .dut_rco(dut_rco),
        .err(a_err), .err_cnt(a_err_cnt), .cmp_cnt(a_cmp),
        .first_sb_Q(a_fsb), .first_dut_Q(a_fdq), .first_idx(a_fidx),
        .state(a_state), .pass(a_pass)
    );

    counter32_checker #(.WARMUP(2), .STOP_ON_ERR(1'b1)) u_dut_stop (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .sb_Q(sb_Q), .sb_rco(sb_rco), .dut_Q(dut_Q), .dut_rco(dut_rco),
        .err(b_err), .err_cnt(b_err_cnt), .cmp_cnt(b_cmp),
        .first_sb_Q(b_fsb), .first_dut_Q(b_fdq), .first_idx(b_fidx),
        .state(b_state), .pass(b_pass)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [31:0] sb;
        logic [31:0] dq;
        logic [1:0]  st_a;
        logic        err;
        logic [15:0] ecnt;
        logic [31:0] cmp_a;
        logic        pass_a;
        logic [31:0] fsb;
        logic [31:0] fdq;
        logic [31:0] fidx;
        logic [1:0]  st_b;
        logic [31:0] cmp_b;
        logic        pass_b;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errs_a;
        int errs_b;

        vt[0]  = '{1'b1, 1'b0, 32'd0,  32'd0,  2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 32'd1,  32'd1,  2'd1, 1'b0, 16'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd1, 32'd0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'd2,  32'd2,  2'd2, 1'b0, 16'd0, 32'd0, 1'b1, 32'd0, 32'd0, 32'd0, 2'd2, 32'd0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 32'd3,  32'd3,  2'd2, 1'b0, 16'd0, 32'd1, 1'b1, 32'd0, 32'd0, 32'd0, 2'd2, 32'd1, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 32'd4,  32'd5,  2'd2, 1'b0, 16'd0, 32'd2, 1'b1, 32'd0, 32'd0, 32'd0, 2'd2, 32'd2, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 32'd5,  32'd5,  2'd2, 1'b1, 16'd1, 32'd3, 1'b0, 32'd4, 32'd5, 32'd3, 2'd3, 32'd3, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 32'd6,  32'd6,  2'd2, 1'b0, 16'd1, 32'd4, 1'b0, 32'd4, 32'd5, 32'd3, 2'd3, 32'd3, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 32'd7,  32'd7,  2'd2, 1'b0, 16'd1, 32'd5, 1'b0, 32'd4, 32'd5, 32'd3, 2'd3, 32'd3, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 32'd8,  32'd9,  2'd2, 1'b0, 16'd1, 32'd5, 1'b0, 32'd4, 32'd5, 32'd3, 2'd3, 32'd3, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 32'd10, 32'd11, 2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 32'd0,  32'd0,  2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0};

        reset   = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        sb_Q    = '0;
        dut_Q   = '0;
        sb_rco  = 1'b0;
        dut_rco = 1'b0;

        // Reset state
        #2;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_err_cnt", 32'(a_err_cnt), 32'd0);
        chk("rst_cmp_cnt", a_cmp, 32'd0);
        chk("rst_first_idx", a_fidx, 32'd0);
        chk("rst_pass", 32'(a_pass), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single corruption, first-mismatch capture, clear racing a mismatch
        for (int i = 0; i < 11; i++) begin
            enable = vt[i].en;
            clear  = vt[i].clr;
            sb_Q   = vt[i].sb;
            dut_Q  = vt[i].dq;
            step();
            chk($sformatf("tbl%0d_state", i), 32'(a_state), 32'(vt[i].st_a));
            chk($sformatf("tbl%0d_err", i), 32'(a_err), 32'(vt[i].err));
            chk($sformatf("tbl%0d_err_cnt", i), 32'(a_err_cnt), 32'(vt[i].ecnt));
            chk($sformatf("tbl%0d_cmp_cnt", i), a_cmp, vt[i].cmp_a);
            chk($sformatf("tbl%0d_pass", i), 32'(a_pass), 32'(vt[i].pass_a));
            chk($sformatf("tbl%0d_first_sb", i), a_fsb, vt[i].fsb);
            chk($sformatf("tbl%0d_first_dut", i), a_fdq, vt[i].fdq);
            chk($sformatf("tbl%0d_first_idx", i), a_fidx, vt[i].fidx);
            chk($sformatf("tbl%0d_stop_state", i), 32'(b_state), 32'(vt[i].st_b));
            chk($sformatf("tbl%0d_stop_err", i), 32'(b_err), 32'(vt[i].err));
            chk($sformatf("tbl%0d_stop_err_cnt", i), 32'(b_err_cnt), 32'(vt[i].ecnt));
            chk($sformatf("tbl%0d_stop_cmp_cnt", i), b_cmp, vt[i].cmp_b);
            chk($sformatf("tbl%0d_stop_pass", i), 32'(b_pass), 32'(vt[i].pass_b));
        end
        clear = 1'b0;

        // Identical ramps: 2 warm-up samples then 10 compared
        errs_a = 0;
        for (int i = 0; i < 12; i++) begin
            enable = 1'b1;
            sb_Q   = 32'(i);
            dut_Q  = 32'(i);
            step();
            errs_a += int'(a_err);
            if (i == 1) chk("ramp_warm_state", 32'(a_state), 32'd1);
            if (i == 2) chk("ramp_check_state", 32'(a_state), 32'd2);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            errs_a += int'(a_err);
        end
        chk("ramp_err_pulses", 32'(errs_a), 32'd0);
        chk("ramp_cmp_cnt", a_cmp, 32'd10);
        chk("ramp_state", 32'(a_state), 32'd2);
        chk("ramp_pass", 32'(a_pass), 32'd1);

        // rco disagreement at the 0xFFFFFFFF -> 0 wrap with Q equal
        errs_a = 0;
        enable  = 1'b1;
        sb_Q    = 32'hFFFF_FFFF;
        dut_Q   = 32'hFFFF_FFFF;
        sb_rco  = 1'b1;
        dut_rco = 1'b0;
        step();
        errs_a += int'(a_err);
        sb_Q    = 32'h0;
        dut_Q   = 32'h0;
        sb_rco  = 1'b0;
        dut_rco = 1'b0;
        step();
        errs_a += int'(a_err);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            errs_a += int'(a_err);
        end
        chk("wrap_err_pulses", 32'(errs_a), RCO_EN ? 32'd1 : 32'd0);
        chk("wrap_err_cnt", 32'(a_err_cnt), RCO_EN ? 32'd1 : 32'd0);
        chk("wrap_cmp_cnt", a_cmp, 32'd12);

        // Stop-on-error: one mismatch then five more, then clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        errs_b = 0;
        for (int i = 0; i < 2; i++) begin
            enable = 1'b1;
            sb_Q   = 32'(i);
            dut_Q  = 32'(i);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            sb_Q  = 32'(100 + i);
            dut_Q = 32'(200 + i);
            step();
            errs_b += int'(b_err);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            errs_b += int'(b_err);
        end
        chk("halt_state", 32'(b_state), 32'd3);
        chk("halt_err_pulses", 32'(errs_b), 32'd1);
        chk("halt_err_cnt", 32'(b_err_cnt), 32'd1);
        chk("halt_cmp_cnt", b_cmp, 32'd1);
        chk("halt_first_idx", b_fidx, 32'd1);
        chk("free_err_cnt", 32'(a_err_cnt), 32'd6);
        chk("free_cmp_cnt", a_cmp, 32'd6);
        chk("free_first_sb", a_fsb, 32'd100);
        chk("free_first_dut", a_fdq, 32'd200);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("halt_clr_state", 32'(b_state), 32'd0);
        chk("halt_clr_err_cnt", 32'(b_err_cnt), 32'd0);
        chk("halt_clr_cmp_cnt", b_cmp, 32'd0);
        chk("halt_clr_first_idx", b_fidx, 32'd0);
        chk("halt_clr_first_dut", b_fdq, 32'd0);

        // 0x10000 mismatches: error count saturates while err keeps pulsing
        enable = 1'b1;
        sb_Q   = 32'd0;
        dut_Q  = 32'd1;
        for (int i = 0; i < 32'h10003; i++) begin
            step();
        end
        chk("sat_err_cnt", 32'(a_err_cnt), 32'h0000_FFFF);
        chk("sat_cmp_cnt", a_cmp, 32'h0001_0000);
        chk("sat_err_still_pulses", 32'(a_err), 32'd1);
        chk("sat_state", 32'(a_state), 32'd2);

        // Asynchronous reset mid-CHECK, between edges
        #3;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(a_state), 32'd0);
        chk("arst_err", 32'(a_err), 32'd0);
        chk("arst_err_cnt", 32'(a_err_cnt), 32'd0);
        chk("arst_cmp_cnt", a_cmp, 32'd0);
        chk("arst_first_sb", a_fsb, 32'd0);
        chk("arst_first_dut", a_fdq, 32'd0);
        chk("arst_first_idx", a_fidx, 32'd0);
        chk("arst_pass", 32'(a_pass), 32'd0);
        enable = 1'b0;
        reset  = 1'b1;
        step();
        chk("arst_rel_state", 32'(a_state), 32'd0);
        enable = 1'b1;
        sb_Q   = 32'd5;
        dut_Q  = 32'd5;
        step();
        enable = 1'b0;
        step();
        chk("arst_rewarm_state", 32'(a_state), 32'd1);
        chk("arst_rewarm_cmp", a_cmp, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
